// File: rtl/video_timing_pkg.sv
// Shared types, standard mode timings and helpers for the video_timing generator.
package video_timing_pkg;

  // 1280x720@60 (1650x750 total, positive syncs)
  localparam int unsigned HD_H_ACTIVE = 1280;
  localparam int unsigned HD_H_FP     = 110;
  localparam int unsigned HD_H_SYNC   = 40;
  localparam int unsigned HD_H_BP     = 220;
  localparam int unsigned HD_V_ACTIVE = 720;
  localparam int unsigned HD_V_FP     = 5;
  localparam int unsigned HD_V_SYNC   = 5;
  localparam int unsigned HD_V_BP     = 20;
  localparam logic        HD_H_POL    = 1'b1;
  localparam logic        HD_V_POL    = 1'b1;

  // 640x480@60 (800x525 total, negative syncs)
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam logic        VGA_H_POL    = 1'b0;
  localparam logic        VGA_V_POL    = 1'b0;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        de;
    logic        h_sync;
    logic        v_sync;
    logic        line_start;
    logic        frame_start;
  } video_timing_t;

  // Value a wrap_counter will hold after the coming edge.
  function automatic logic [15:0] count_after(input logic [15:0] cnt, input logic inc,
                                              input logic wrap);
    if (wrap)     return '0;
    else if (inc) return cnt + 16'd1;
    else          return cnt;
  endfunction

  // True when start <= v < start + len.
  function automatic logic in_window(input logic [15:0] v, input int unsigned start,
                                     input int unsigned len);
    return (32'(v) >= start) && (32'(v) < start + len);
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster timing bundle as seen by gfx and the display encoder.
// o_frame_cnt is carried only when VIDEO_TIMING_FRAME_CNT_EN is defined.
interface video_timing_if;
  logic [15:0] x;
  logic [15:0] y;
  logic        de;
  logic        h_sync;
  logic        v_sync;
  logic        line_start;
  logic        frame_start;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    output x, y, de, h_sync, v_sync, line_start, frame_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input x, y, de, h_sync, v_sync, line_start, frame_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/video_timing_wrap_counter.sv
// Modulo-(MAX+1) counter; resets to MAX so the first increment lands on 0.
module wrap_counter #(
  parameter int unsigned     WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX  = '1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_wrap
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign o_wrap = i_inc && (cnt_q == MAX);
  assign o_cnt  = cnt_q;

  // Next count: hold, increment, or return to zero after MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (o_wrap)     cnt_d = '0;
    else if (i_inc) cnt_d = cnt_q + WIDTH'(1);
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= MAX;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/video_timing.sv
// Free-running raster timing generator feeding gfx and the display encoder.
// Optional: define VIDEO_TIMING_FRAME_CNT_EN to add the o_frame_cnt output.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter logic        H_POL    = 1'b1,
  parameter logic        V_POL    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_de,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_line_start,
  output logic        o_frame_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  , output logic [15:0] o_frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 65536 || V_TOTAL > 65536) begin : g_bad_total
    $error("video_timing: H_TOTAL and V_TOTAL must not exceed 65536");
  end
  if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
    $error("video_timing: H_SYNC and V_SYNC must be at least 1");
  end

  logic [15:0]   h_cnt;
  logic [15:0]   v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic [15:0]   h_nxt;
  logic [15:0]   v_nxt;
  video_timing_t vt_q;
  video_timing_t vt_d;

  wrap_counter #(.WIDTH(16), .MAX(16'(H_TOTAL - 1))) u_h_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (1'b1),
    .o_cnt   (h_cnt),
    .o_wrap  (h_wrap)
  );

  wrap_counter #(.WIDTH(16), .MAX(16'(V_TOTAL - 1))) u_v_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (h_wrap),
    .o_cnt   (v_cnt),
    .o_wrap  (v_wrap)
  );

  // Outputs are decoded from the counters' upcoming values so the first edge
  // after reset release already presents pixel (0,0); v_nxt only moves when
  // h wraps, which keeps v_sync edges at x == 0.
  assign h_nxt = count_after(h_cnt, 1'b1, h_wrap);
  assign v_nxt = count_after(v_cnt, h_wrap, v_wrap);

  // Decode one pixel's worth of timing signals.
  always_comb begin
    vt_d             = '0;
    vt_d.x           = h_nxt;
    vt_d.y           = v_nxt;
    vt_d.de          = (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE);
    vt_d.h_sync      = in_window(h_nxt, H_ACTIVE + H_FP, H_SYNC) ? H_POL : ~H_POL;
    vt_d.v_sync      = in_window(v_nxt, V_ACTIVE + V_FP, V_SYNC) ? V_POL : ~V_POL;
    vt_d.line_start  = (h_nxt == '0);
    vt_d.frame_start = (h_nxt == '0) && (v_nxt == '0);
  end

  // Output register; syncs rest at their inactive level in reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vt_q        <= '0;
      vt_q.h_sync <= ~H_POL;
      vt_q.v_sync <= ~V_POL;
    end else begin
      vt_q        <= vt_d;
    end
  end

  assign o_x           = vt_q.x;
  assign o_y           = vt_q.y;
  assign o_de          = vt_q.de;
  assign o_h_sync      = vt_q.h_sync;
  assign o_v_sync      = vt_q.v_sync;
  assign o_line_start  = vt_q.line_start;
  assign o_frame_start = vt_q.frame_start;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Frame counter steps on the same edge that raises o_frame_start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              frame_cnt_q <= '0;
    else if (vt_d.frame_start) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

endmodule
